// File: rtl/display_clear_delay_ram.sv
// Support block for the waveform display controller: screen-clear raster engine,
// inter-frame delay timer and a 256x8 trace sample RAM, each with its own handshake.
module display_clear_delay_ram #(
  parameter int unsigned H_PIXELS     = 160,
  parameter int unsigned V_PIXELS     = 120,
  parameter logic [11:0] CLEAR_COLOR  = 12'h000,
  parameter int unsigned DELAY_CYCLES = 10008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_enable,
  input  logic        clear_restart,
  output logic [7:0]  clear_x,
  output logic [7:0]  clear_y,
  output logic [11:0] clear_color,
  output logic        clear_finished,
  input  logic        delay_enable,
  input  logic        delay_restart,
  output logic        delay_finished,
  input  logic        wr_en,
  input  logic [7:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        rd_en,
  input  logic [7:0]  rd_addr,
  output logic [7:0]  rd_data
);

  localparam int unsigned DW = $clog2(DELAY_CYCLES + 1);
  localparam logic [7:0] X_LAST = 8'(H_PIXELS - 1);
  localparam logic [7:0] Y_LAST = 8'(V_PIXELS - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DELAY_CYCLES - 1);

  logic [DW-1:0] delay_count;
  logic [7:0]    mem [256];

  assign clear_color = CLEAR_COLOR;

  // X-major raster sweep; coordinates park on the last pixel once finished
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clear_x        <= 8'd0;
      clear_y        <= 8'd0;
      clear_finished <= 1'b0;
    end else if (clear_restart) begin
      clear_x        <= 8'd0;
      clear_y        <= 8'd0;
      clear_finished <= 1'b0;
    end else if (clear_enable && !clear_finished) begin
      if (clear_x < X_LAST) begin
        clear_x <= clear_x + 8'd1;
      end else if (clear_y < Y_LAST) begin
        clear_x <= 8'd0;
        clear_y <= clear_y + 8'd1;
      end else begin
        clear_finished <= 1'b1;
      end
    end
  end

  // Sticky timer: finished rises on the DELAY_CYCLES-th enabled edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      delay_count    <= '0;
      delay_finished <= 1'b0;
    end else if (delay_restart) begin
      delay_count    <= '0;
      delay_finished <= 1'b0;
    end else if (delay_enable && !delay_finished) begin
      if (delay_count == D_LAST) begin
        delay_finished <= 1'b1;
      end else begin
        delay_count <= delay_count + DW'(1);
      end
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; same-address write on the same edge yields the old word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= 8'd0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_display_clear_delay_ram.sv
// Directed self-checking bench for display_clear_delay_ram (H=4, V=3, DELAY=5).
module tb_display_clear_delay_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_enable, clear_restart;
  logic [7:0]  clear_x, clear_y;
  logic [11:0] clear_color;
  logic        clear_finished;
  logic        delay_enable, delay_restart, delay_finished;
  logic        wr_en, rd_en;
  logic [7:0]  wr_addr, wr_data, rd_addr, rd_data;

  int errors = 0;
  int checks = 0;

  display_clear_delay_ram #(
    .H_PIXELS(4), .V_PIXELS(3), .CLEAR_COLOR(12'hABC), .DELAY_CYCLES(5)
  ) dut (
    .clk(clk), .reset(reset),
    .clear_enable(clear_enable), .clear_restart(clear_restart),
    .clear_x(clear_x), .clear_y(clear_y), .clear_color(clear_color),
    .clear_finished(clear_finished),
    .delay_enable(delay_enable), .delay_restart(delay_restart),
    .delay_finished(delay_finished),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_enable = 1'b0; clear_restart = 1'b0;
    delay_enable = 1'b0; delay_restart = 1'b0;
    wr_en = 1'b0; wr_addr = 8'd0; wr_data = 8'd0;
    rd_en = 1'b0; rd_addr = 8'd0;
    step(); step();
    checks++;
    if ({clear_x, clear_y, clear_finished, delay_finished, rd_data} !== 26'd0) begin
      errors++;
      $display("FAIL reset_state: x=%0d y=%0d cf=%b df=%b rd=%h, required all zero",
               clear_x, clear_y, clear_finished, delay_finished, rd_data);
    end
    checks++;
    if (clear_color !== 12'hABC) begin
      errors++;
      $display("FAIL clear_color: got %h required abc", clear_color);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_clear_sweep();
    logic [7:0] ex, ey;
    logic       ef;
    clear_enable = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k < 12) begin ex = 8'(k % 4); ey = 8'(k / 4); ef = 1'b0; end
      else        begin ex = 8'd3;      ey = 8'd2;      ef = 1'b1; end
      checks++;
      if (clear_x !== ex || clear_y !== ey || clear_finished !== ef) begin
        errors++;
        $display("FAIL sweep_edge%0d: got (%0d,%0d,f=%b) required (%0d,%0d,f=%b)",
                 k, clear_x, clear_y, clear_finished, ex, ey, ef);
      end
    end
    clear_enable = 1'b0;
  endtask

  task automatic test_clear_toggle();
    int n;
    logic [7:0] ex, ey;
    logic       ef;
    clear_restart = 1'b1;
    step();
    clear_restart = 1'b0;
    checks++;
    if (clear_x !== 8'd0 || clear_y !== 8'd0 || clear_finished !== 1'b0) begin
      errors++;
      $display("FAIL toggle_restart: got (%0d,%0d,f=%b) required (0,0,f=0)",
               clear_x, clear_y, clear_finished);
    end
    n = 0;
    for (int c = 0; c < 24; c++) begin
      clear_enable = (c % 2 == 0);
      if (clear_enable) n++;
      step();
      if (n < 12) begin ex = 8'(n % 4); ey = 8'(n / 4); ef = 1'b0; end
      else        begin ex = 8'd3;      ey = 8'd2;      ef = 1'b1; end
      checks++;
      if (clear_x !== ex || clear_y !== ey || clear_finished !== ef) begin
        errors++;
        $display("FAIL toggle_cycle%0d: got (%0d,%0d,f=%b) required (%0d,%0d,f=%b)",
                 c, clear_x, clear_y, clear_finished, ex, ey, ef);
      end
    end
    clear_enable = 1'b1;
    clear_restart = 1'b1;
    step();
    clear_restart = 1'b0;
    clear_enable = 1'b0;
    checks++;
    if (clear_x !== 8'd0 || clear_y !== 8'd0 || clear_finished !== 1'b0) begin
      errors++;
      $display("FAIL restart_priority: got (%0d,%0d,f=%b) required (0,0,f=0)",
               clear_x, clear_y, clear_finished);
    end
  endtask

  task automatic test_delay();
    delay_restart = 1'b1;
    step();
    delay_restart = 1'b0;
    delay_enable = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++;
      if (delay_finished !== (k >= 5)) begin
        errors++;
        $display("FAIL delay_edge%0d: got %b required %b", k, delay_finished, k >= 5);
      end
    end
    delay_enable = 1'b0;
    delay_restart = 1'b1;
    step();
    delay_restart = 1'b0;
    checks++;
    if (delay_finished !== 1'b0) begin
      errors++;
      $display("FAIL delay_restart: got %b required 0", delay_finished);
    end
    // three enabled edges, then an async reset must zero the count
    delay_enable = 1'b1;
    step(); step(); step();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (delay_finished !== (k == 5)) begin
        errors++;
        $display("FAIL delay_after_reset_edge%0d: got %b required %b",
                 k, delay_finished, k == 5);
      end
    end
    delay_enable = 1'b0;
  endtask

  task automatic test_ram();
    wr_en = 1'b1; wr_addr = 8'h10; wr_data = 8'hA5;
    step();
    wr_addr = 8'hFF; wr_data = 8'h3C;
    step();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = 8'h10;
    step();
    checks++;
    if (rd_data !== 8'hA5) begin
      errors++;
      $display("FAIL ram_read_10: got %h required a5", rd_data);
    end
    rd_addr = 8'hFF;
    step();
    checks++;
    if (rd_data !== 8'h3C) begin
      errors++;
      $display("FAIL ram_read_ff: got %h required 3c", rd_data);
    end
    rd_en = 1'b0;
    rd_addr = 8'h10;
    step();
    rd_addr = 8'h00;
    step();
    checks++;
    if (rd_data !== 8'h3C) begin
      errors++;
      $display("FAIL ram_hold: got %h required 3c", rd_data);
    end
  endtask

  task automatic test_same_edge();
    wr_en = 1'b1; wr_addr = 8'h10; wr_data = 8'h5A;
    rd_en = 1'b1; rd_addr = 8'h10;
    step();
    wr_en = 1'b0;
    checks++;
    if (rd_data !== 8'hA5) begin
      errors++;
      $display("FAIL same_edge_old: got %h required a5", rd_data);
    end
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_data !== 8'h5A) begin
      errors++;
      $display("FAIL same_edge_new: got %h required 5a", rd_data);
    end
  endtask

  task automatic test_async_reset();
    clear_restart = 1'b1;
    step();
    clear_restart = 1'b0;
    clear_enable = 1'b1;
    for (int k = 0; k < 5; k++) step();
    clear_enable = 1'b0;
    checks++;
    if (clear_x !== 8'd1 || clear_y !== 8'd1) begin
      errors++;
      $display("FAIL mid_sweep: got (%0d,%0d) required (1,1)", clear_x, clear_y);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (clear_x !== 8'd0 || clear_y !== 8'd0 || clear_finished !== 1'b0 || rd_data !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: got (%0d,%0d,f=%b) rd=%h required (0,0,f=0) rd=00",
               clear_x, clear_y, clear_finished, rd_data);
    end
    #1 reset = 1'b0;
    clear_enable = 1'b1;
    step();
    clear_enable = 1'b0;
    checks++;
    if (clear_x !== 8'd1 || clear_y !== 8'd0) begin
      errors++;
      $display("FAIL post_reset_step: got (%0d,%0d) required (1,0)", clear_x, clear_y);
    end
  endtask

  initial begin
    test_reset();
    test_clear_sweep();
    test_clear_toggle();
    test_delay();
    test_ram();
    test_same_edge();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
